// File: rtl/uart_tx_ctrl_if.sv
// Host byte handshake, PISO strobes and serial line of the UART transmit controller.
// slave: the controller side; master: the host/PISO/line side.
interface uart_tx_ctrl_if;
  // tx_valid/tx_ready: a byte moves on every clock edge where both are high,
  // and tx_valid does not have to wait for tx_ready before it rises.
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] piso_data;
  logic       piso_ld;
  logic       piso_shift;
  logic       piso_out;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  modport slave (
    input  tx_data, tx_valid, piso_out,
    output tx_ready, piso_data, piso_ld, piso_shift, tx, tx_busy, tx_done
  );

  modport master (
    output tx_data, tx_valid, piso_out,
    input  tx_ready, piso_data, piso_ld, piso_shift, tx, tx_busy, tx_done
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: 1 start, 8 data bits LSB first, 1 stop, no parity.
// Drives an external 8-bit PISO through ld/shift strobes and muxes its output onto tx.
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_ctrl_if.slave  bus,
  output logic [1:0]     state_o
);

  localparam int             CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     LAST_BIT = 3'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  baud_cnt_q, baud_cnt_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic           tx_done_q, tx_done_d;
  logic           shift_d;
  logic           tick;
  logic           accept;
  logic           tx_line;

  assign tick   = (baud_cnt_q == LAST_CNT);
  assign accept = bus.tx_valid && bus.tx_ready;

  // Ready is gated by rst so nothing can be loaded while reset is held.
  assign bus.tx_ready   = (state_q == S_IDLE) && !rst;
  assign bus.piso_ld    = accept;
  assign bus.piso_data  = bus.tx_data;
  assign bus.piso_shift = shift_d;
  assign bus.tx         = tx_line;
  assign bus.tx_busy    = (state_q != S_IDLE);
  assign bus.tx_done    = tx_done_q;
  assign state_o        = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_done_q  <= tx_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = '0;
    bit_cnt_d  = bit_cnt_q;
    tx_done_d  = 1'b0;
    shift_d    = 1'b0;

    if (state_q != S_IDLE) begin
      baud_cnt_d = tick ? '0 : baud_cnt_q + CW'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d   = S_START;
          bit_cnt_d = '0;
        end
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        // The last data bit leaves the PISO untouched: 7 shifts per frame.
        if (tick) begin
          if (bit_cnt_q != LAST_BIT) begin
            shift_d   = !rst;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end else begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          state_d   = S_IDLE;
          tx_done_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    tx_line = 1'b1;
    unique case (state_q)
      S_START: tx_line = 1'b0;
      S_DATA:  tx_line = bus.piso_out;
      default: tx_line = 1'b1;
    endcase
  end

endmodule
